// File: rtl/ltc2600_channel_scheduler.sv
// Per-channel setpoint/power-down scheduler for an LTC2600-style serial DAC writer.
// Keeps a shadow of every channel and issues one writer transaction at a time, round-robin.
module ltc2600_channel_scheduler #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned N_CH           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    input  logic [2:0]            set_ch,
    input  logic [DATA_WIDTH-1:0] set_data,
    input  logic                  pd_valid,
    input  logic [2:0]            pd_ch,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  wr_start,
    output logic [3:0]            wr_command,
    output logic [3:0]            wr_address,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  busy,
    output logic [N_CH-1:0]       pending,
    output logic                  timeout_err,
    output logic [2:0]            err_ch
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] CmdWrite = 4'b0011;
    localparam logic [3:0] CmdPd    = 4'b0100;
    localparam logic [3:0] CmdNop   = 4'b1111;

    typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

    state_e                state_q, state_d;
    logic [N_CH-1:0]       dirty_q, dirty_d;
    logic [N_CH-1:0]       pd_pend_q, pd_pend_d;
    logic [DATA_WIDTH-1:0] shadow_q [N_CH];
    logic [DATA_WIDTH-1:0] shadow_d [N_CH];
    logic [2:0]            rr_ptr_q, rr_ptr_d;
    logic [2:0]            cur_ch_q, cur_ch_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  wr_start_q, wr_start_d;
    logic [3:0]            wr_command_q, wr_command_d;
    logic [3:0]            wr_address_q, wr_address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [2:0]            err_ch_q, err_ch_d;

    logic                  found;
    logic [2:0]            sel_ch;
    logic [2:0]            idx;
    logic [2:0]            next_rr;

    assign pending = dirty_q | pd_pend_q;
    assign next_rr = (cur_ch_q == 3'(N_CH - 1)) ? 3'd0 : cur_ch_q + 3'd1;

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        sel_ch = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = 3'((32'(rr_ptr_q) + i) % N_CH);
            if (!found && pending[idx]) begin
                found  = 1'b1;
                sel_ch = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        dirty_d       = dirty_q;
        pd_pend_d     = pd_pend_q;
        shadow_d      = shadow_q;
        rr_ptr_d      = rr_ptr_q;
        cur_ch_d      = cur_ch_q;
        cnt_d         = cnt_q;
        wr_start_d    = 1'b0;
        wr_command_d  = wr_command_q;
        wr_address_d  = wr_address_q;
        wr_data_d     = wr_data_q;
        timeout_err_d = timeout_err_q;
        err_ch_d      = err_ch_q;

        if (clr_err) timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                wr_command_d = CmdNop;
                if (found) begin
                    wr_start_d   = 1'b1;
                    cur_ch_d     = sel_ch;
                    cnt_d        = '0;
                    state_d      = StWait;
                    wr_address_d = {1'b0, sel_ch};
                    if (pd_pend_q[sel_ch]) begin
                        wr_command_d = CmdPd;
                        wr_data_d    = '0;
                    end else begin
                        wr_command_d = CmdWrite;
                        wr_data_d    = shadow_q[sel_ch];
                    end
                    dirty_d[sel_ch]   = 1'b0;
                    pd_pend_d[sel_ch] = 1'b0;
                end
            end
            StWait: begin
                if (wr_done) begin
                    state_d  = StGap;
                    rr_ptr_d = next_rr;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    // Timed-out request is dropped; the timeout wins over clr_err.
                    timeout_err_d = 1'b1;
                    err_ch_d      = cur_ch_q;
                    state_d       = StGap;
                    rr_ptr_d      = next_rr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                state_d      = StIdle;
                wr_command_d = CmdNop;
            end
            default: state_d = StIdle;
        endcase

        // New requests land on top of the issue-clear, so in-flight channels get re-queued.
        if (flush) dirty_d = dirty_d | ~pd_pend_q;
        if (set_valid && (32'(set_ch) < N_CH)) begin
            shadow_d[set_ch]  = set_data;
            dirty_d[set_ch]   = 1'b1;
            pd_pend_d[set_ch] = 1'b0;
        end
        if (pd_valid && (32'(pd_ch) < N_CH)) begin
            pd_pend_d[pd_ch] = 1'b1;
            dirty_d[pd_ch]   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            dirty_q       <= '0;
            pd_pend_q     <= '0;
            shadow_q      <= '{default: '0};
            rr_ptr_q      <= '0;
            cur_ch_q      <= '0;
            cnt_q         <= '0;
            wr_start_q    <= 1'b0;
            wr_command_q  <= CmdNop;
            wr_address_q  <= '0;
            wr_data_q     <= '0;
            timeout_err_q <= 1'b0;
            err_ch_q      <= '0;
        end else begin
            state_q       <= state_d;
            dirty_q       <= dirty_d;
            pd_pend_q     <= pd_pend_d;
            shadow_q      <= shadow_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_ch_q      <= cur_ch_d;
            cnt_q         <= cnt_d;
            wr_start_q    <= wr_start_d;
            wr_command_q  <= wr_command_d;
            wr_address_q  <= wr_address_d;
            wr_data_q     <= wr_data_d;
            timeout_err_q <= timeout_err_d;
            err_ch_q      <= err_ch_d;
        end
    end

    assign wr_start    = wr_start_q;
    assign wr_command  = wr_command_q;
    assign wr_address  = wr_address_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = timeout_err_q;
    assign err_ch      = err_ch_q;

endmodule

// File: tb/tb_ltc2600_channel_scheduler.sv
// Directed bench for ltc2600_channel_scheduler: latency, round-robin, conflicts,
// flush, in-flight rewrite, timeout and mid-transaction reset.
module tb_ltc2600_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_valid;
    logic [2:0]  set_ch;
    logic [15:0] set_data;
    logic        pd_valid;
    logic [2:0]  pd_ch;
    logic        flush;
    logic        clr_err;
    logic        wr_start;
    logic [3:0]  wr_command;
    logic [3:0]  wr_address;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        busy;
    logic [7:0]  pending;
    logic        timeout_err;
    logic [2:0]  err_ch;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ltc2600_channel_scheduler #(
        .DATA_WIDTH    (16),
        .N_CH          (8),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .set_valid  (set_valid),
        .set_ch     (set_ch),
        .set_data   (set_data),
        .pd_valid   (pd_valid),
        .pd_ch      (pd_ch),
        .flush      (flush),
        .clr_err    (clr_err),
        .wr_start   (wr_start),
        .wr_command (wr_command),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .busy       (busy),
        .pending    (pending),
        .timeout_err(timeout_err),
        .err_ch     (err_ch)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_set(input logic [2:0] ch, input logic [15:0] data);
        set_valid = 1'b1;
        set_ch    = ch;
        set_data  = data;
        step();
        set_valid = 1'b0;
    endtask

    task automatic check_start(input string tag, input logic [3:0] addr, input logic [3:0] cmd,
                               input logic [15:0] data);
        check({tag, "_start"}, wr_start, 1);
        check({tag, "_addr"}, wr_address, addr);
        check({tag, "_cmd"}, wr_command, cmd);
        check({tag, "_data"}, wr_data, data);
    endtask

    // wr_done now -> GAP -> IDLE -> next start.
    task automatic finish_and_next(input string tag, input logic [3:0] addr,
                                   input logic [3:0] cmd, input logic [15:0] data);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check({tag, "_gap_start"}, wr_start, 0);
        check({tag, "_gap_busy"}, busy, 1);
        step();
        check({tag, "_idle_start"}, wr_start, 0);
        check({tag, "_idle_nop"}, wr_command, 4'b1111);
        step();
        check_start(tag, addr, cmd, data);
    endtask

    task automatic finish_last(input string tag);
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        step();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_cmd"}, wr_command, 4'b1111);
        step();
        check({tag, "_no_start"}, wr_start, 0);
    endtask

    initial begin
        rst = 1'b1; set_valid = 1'b0; set_ch = '0; set_data = '0;
        pd_valid = 1'b0; pd_ch = '0; flush = 1'b0; clr_err = 1'b0; wr_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_start", wr_start, 0);
        check("rst_cmd", wr_command, 4'b1111);
        check("rst_addr", wr_address, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_err", timeout_err, 0);
        check("rst_errch", err_ch, 0);

        // Single set: pending at N+1, start at N+2.
        do_set(3'd3, 16'hABCD);
        check("single_pend", pending, 8'h08);
        check("single_early", wr_start, 0);
        step();
        check_start("single", 4'd3, 4'b0011, 16'hABCD);
        check("single_pend_clr", pending, 0);
        check("single_busy", busy, 1);
        step();
        check("single_pulse", wr_start, 0);
        check("single_hold", wr_command, 4'b0011);
        finish_last("single");

        // Round-robin: queue 5,1,6 while ch7 is in flight; pointer wraps to 0.
        do_set(3'd7, 16'h7777);
        step();
        check_start("rr7", 4'd7, 4'b0011, 16'h7777);
        do_set(3'd5, 16'h5555);
        do_set(3'd1, 16'h1111);
        do_set(3'd6, 16'h6666);
        check("rr_pend", pending, 8'h62);
        finish_and_next("rr1", 4'd1, 4'b0011, 16'h1111);
        finish_and_next("rr5", 4'd5, 4'b0011, 16'h5555);
        finish_and_next("rr6", 4'd6, 4'b0011, 16'h6666);
        finish_last("rr");

        // Same-cycle set and power-down on ch2: power-down wins, shadow still updated.
        set_valid = 1'b1; set_ch = 3'd2; set_data = 16'h1234;
        pd_valid  = 1'b1; pd_ch  = 3'd2;
        step();
        set_valid = 1'b0; pd_valid = 1'b0;
        check("conf_pend", pending, 8'h04);
        step();
        check_start("conf", 4'd2, 4'b0100, 16'h0000);
        finish_last("conf");

        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        check("stray_done_busy", busy, 0);
        check("stray_done_start", wr_start, 0);

        // Flush rewrites every channel from shadow, starting after ch2.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_pend", pending, 8'hFF);
        step();
        check_start("fl3", 4'd3, 4'b0011, 16'hABCD);
        finish_and_next("fl4", 4'd4, 4'b0011, 16'h0000);
        finish_and_next("fl5", 4'd5, 4'b0011, 16'h5555);
        finish_and_next("fl6", 4'd6, 4'b0011, 16'h6666);
        finish_and_next("fl7", 4'd7, 4'b0011, 16'h7777);
        finish_and_next("fl0", 4'd0, 4'b0011, 16'h0000);
        finish_and_next("fl1", 4'd1, 4'b0011, 16'h1111);
        finish_and_next("fl2", 4'd2, 4'b0011, 16'h1234);
        finish_last("flush");

        // In-flight rewrite of ch4.
        do_set(3'd4, 16'h0001);
        step();
        check_start("rw1", 4'd4, 4'b0011, 16'h0001);
        do_set(3'd4, 16'h0002);
        check("rw_pend", pending, 8'h10);
        check("rw_hold_data", wr_data, 16'h0001);
        check("rw_hold_addr", wr_address, 4'd4);
        step();
        check("rw_hold_data2", wr_data, 16'h0001);
        check("rw_hold_cmd", wr_command, 4'b0011);
        finish_and_next("rw2", 4'd4, 4'b0011, 16'h0002);
        finish_last("rw");

        // Timeout on ch6 after 15 WAIT cycles, then ch1 is served.
        do_set(3'd6, 16'h00AA);
        do_set(3'd1, 16'h00BB);
        check_start("to6", 4'd6, 4'b0011, 16'h00AA);
        repeat (14) step();
        check("to_not_yet", timeout_err, 0);
        check("to_still_wait", busy, 1);
        step();
        check("to_err", timeout_err, 1);
        check("to_errch", err_ch, 3'd6);
        check("to_gap_start", wr_start, 0);
        step();
        check("to_idle_start", wr_start, 0);
        step();
        check_start("to1", 4'd1, 4'b0011, 16'h00BB);
        check("to_sticky", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("to_cleared", timeout_err, 0);
        finish_last("to");

        // Reset in the middle of a WAIT, with a request during reset.
        do_set(3'd5, 16'h0F0F);
        step();
        check_start("mr5", 4'd5, 4'b0011, 16'h0F0F);
        do_set(3'd6, 16'h0606);
        rst = 1'b1; set_valid = 1'b1; set_ch = 3'd7; set_data = 16'h7070;
        step();
        rst = 1'b0; set_valid = 1'b0;
        check("mr_start", wr_start, 0);
        check("mr_cmd", wr_command, 4'b1111);
        check("mr_addr", wr_address, 0);
        check("mr_data", wr_data, 0);
        check("mr_busy", busy, 0);
        check("mr_pend", pending, 0);
        step();
        check("mr_quiet_start", wr_start, 0);
        check("mr_quiet_pend", pending, 0);

        // Shadow and rr pointer were cleared by reset.
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check_start("mr_fl0", 4'd0, 4'b0011, 16'h0000);
        finish_and_next("mr_fl1", 4'd1, 4'b0011, 16'h0000);
        rst = 1'b1;
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
